// File: rtl/seven_seg_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_pkg
// Description : Shared segment patterns, digit indices and edit-mode encodings
//               for the 8-digit multiplexed clock display.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_scan_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] IDX_SEC_ONES = 3'd0;
    localparam logic [2:0] IDX_SEC_TENS = 3'd1;
    localparam logic [2:0] IDX_MIN_ONES = 3'd2;
    localparam logic [2:0] IDX_MIN_TENS = 3'd3;
    localparam logic [2:0] IDX_HRS_ONES = 3'd4;
    localparam logic [2:0] IDX_HRS_TENS = 3'd5;

    localparam logic [2:0] MODE_SEC = 3'd1;
    localparam logic [2:0] MODE_MIN = 3'd2;
    localparam logic [2:0] MODE_HRS = 3'd3;

    typedef logic [5:0] digit_t;

    typedef enum logic [0:0] {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blink_phase_t;

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_if
// Description : Digit values and edit mode in, anode/segment drive out.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_if;
    logic [2:0] mode;
    logic [5:0] hrs_tens;
    logic [5:0] hrs_ones;
    logic [5:0] min_tens;
    logic [5:0] min_ones;
    logic [5:0] sec_tens;
    logic [5:0] sec_ones;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output mode, hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones,
        input  an, seg, dp
    );

    modport slave (
        input  mode, hrs_tens, hrs_ones, min_tens, min_ones, sec_tens, sec_ones,
        output an, seg, dp
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : 6-bit digit value to active-low segment pattern; 10-63 show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import seven_seg_scan_pkg::*;
(
    input  wire  digit_t     value,
    output logic [6:0]       pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (value)
            6'd0:    pattern = SEG_0;
            6'd1:    pattern = SEG_1;
            6'd2:    pattern = SEG_2;
            6'd3:    pattern = SEG_3;
            6'd4:    pattern = SEG_4;
            6'd5:    pattern = SEG_5;
            6'd6:    pattern = SEG_6;
            6'd7:    pattern = SEG_7;
            6'd8:    pattern = SEG_8;
            6'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan
// Description : Multiplexed HH.MM.SS driver with anti-ghost blanking and field blink.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan
    import seven_seg_scan_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter int BLINK_DIV    = 25_000_000
)
(
    input  wire logic         clk,
    input  wire logic         reset,
    seven_seg_scan_if.slave   bus
);

    localparam int SLOT_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [SLOT_W-1:0]  r_slot_cnt;
    logic [2:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    blink_phase_t       r_phase;
    logic [2:0]         r_mode_prev;
    logic               r_first;
    digit_t             r_snap [6];
    logic [7:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_slot_wrap;
    logic               w_capture;
    logic               w_mode_change;
    logic               w_blank;
    logic               w_field_hit;
    logic               w_hide;
    logic               w_dp_lit;
    digit_t             w_digit;
    logic [6:0]         w_pattern;
    logic [7:0]         w_an_next;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;

    assign w_slot_wrap   = (r_slot_cnt == SLOT_W'(SCAN_DIV - 1));
    assign w_capture     = r_first || (w_slot_wrap && (r_idx == IDX_HRS_TENS));
    assign w_mode_change = (bus.mode != r_mode_prev);
    assign w_blank       = (r_slot_cnt < SLOT_W'(BLANK_CYCLES));
    assign w_dp_lit      = (r_idx == IDX_MIN_ONES) || (r_idx == IDX_HRS_ONES);
    // A mode change unhides at once so the newly selected field never starts dark
    assign w_hide        = (r_phase == PHASE_HIDDEN) && !w_mode_change && w_field_hit;

    always_comb begin
        w_digit = r_snap[0];
        case (r_idx)
            IDX_SEC_ONES: w_digit = r_snap[0];
            IDX_SEC_TENS: w_digit = r_snap[1];
            IDX_MIN_ONES: w_digit = r_snap[2];
            IDX_MIN_TENS: w_digit = r_snap[3];
            IDX_HRS_ONES: w_digit = r_snap[4];
            IDX_HRS_TENS: w_digit = r_snap[5];
            default:      w_digit = r_snap[0];
        endcase
    end

    always_comb begin
        w_field_hit = 1'b0;
        case (bus.mode)
            MODE_SEC: w_field_hit = (r_idx == IDX_SEC_ONES) || (r_idx == IDX_SEC_TENS);
            MODE_MIN: w_field_hit = (r_idx == IDX_MIN_ONES) || (r_idx == IDX_MIN_TENS);
            MODE_HRS: w_field_hit = (r_idx == IDX_HRS_ONES) || (r_idx == IDX_HRS_TENS);
            default:  w_field_hit = 1'b0;
        endcase
    end

    seg7_decode u_decode (
        .value   (w_digit),
        .pattern (w_pattern)
    );

    // Hidden separator digits keep their anode on so the dp never flickers
    always_comb begin
        w_an_next  = 8'hFF;
        w_seg_next = SEG_BLANK;
        w_dp_next  = 1'b1;
        if (!w_blank) begin
            w_an_next  = ~(8'b1 << r_idx);
            w_seg_next = w_pattern;
            w_dp_next  = ~w_dp_lit;
            if (w_hide) begin
                w_seg_next = SEG_BLANK;
                if (!w_dp_lit) begin
                    w_an_next = 8'hFF;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_idx       <= IDX_SEC_ONES;
            r_blink_cnt <= '0;
            r_phase     <= PHASE_VISIBLE;
            r_mode_prev <= bus.mode;
            r_first     <= 1'b1;
            for (int i = 0; i < 6; i++) begin
                r_snap[i] <= '0;
            end
            r_an        <= 8'hFF;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
        end else begin
            r_mode_prev <= bus.mode;
            r_first     <= 1'b0;

            if (w_slot_wrap) begin
                r_slot_cnt <= '0;
                r_idx      <= (r_idx == IDX_HRS_TENS) ? IDX_SEC_ONES : r_idx + 3'd1;
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end

            if (w_capture) begin
                r_snap[0] <= bus.sec_ones;
                r_snap[1] <= bus.sec_tens;
                r_snap[2] <= bus.min_ones;
                r_snap[3] <= bus.min_tens;
                r_snap[4] <= bus.hrs_ones;
                r_snap[5] <= bus.hrs_tens;
            end

            if (w_mode_change) begin
                r_blink_cnt <= '0;
                r_phase     <= PHASE_VISIBLE;
            end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_phase     <= (r_phase == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end

            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan
// Description : Randomized bench comparing the scanner to a cycle-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int BK    = 64;
    localparam int FRAME = SD * 6;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_if bus ();

    seven_seg_scan #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL),
        .BLINK_DIV    (BK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: everything derives from n, the cycle count since reset release
    logic [6:0]  pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int          n;
    int          bbase;
    logic [2:0]  pm;
    logic [5:0]  msnap [6];
    logic [15:0] exp_out;

    function automatic logic [15:0] predict();
        int         slot, idx, digit;
        logic [7:0] a;
        logic [6:0] s;
        logic       d;
        bit         hidden, field;
        slot = n % SD;
        idx  = (n / SD) % 6;
        if (slot < BL) return 16'hFFFF;
        digit  = int'(msnap[idx]);
        s      = (digit < 10) ? pat[digit] : 7'h3F;
        a      = 8'hFF;
        a[idx] = 1'b0;
        d      = !(idx == 2 || idx == 4);
        hidden = (bus.mode == pm) && ((((n - bbase) / BK) % 2) == 1);
        field  = (bus.mode == 3'd1 && idx < 2) || (bus.mode == 3'd2 && (idx == 2 || idx == 3)) ||
                 (bus.mode == 3'd3 && idx >= 4);
        if (hidden && field) begin
            s = 7'h7F;
            if (d) a = 8'hFF;
        end
        return {a, s, d};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_out <= 16'hFFFF;
            n       <= 0;
            bbase   <= 0;
            for (int i = 0; i < 6; i++) msnap[i] <= 6'd0;
        end else begin
            exp_out <= predict();
            n       <= n + 1;
            if (bus.mode != pm) bbase <= n + 1;
            if (n == 0 || (n % FRAME) == FRAME - 1) begin
                msnap[0] <= bus.sec_ones;
                msnap[1] <= bus.sec_tens;
                msnap[2] <= bus.min_ones;
                msnap[3] <= bus.min_tens;
                msnap[4] <= bus.hrs_ones;
                msnap[5] <= bus.hrs_tens;
            end
        end
        pm <= bus.mode;
    end

    task automatic rand_digits();
        bus.hrs_tens = 6'($urandom_range(0, 9));
        bus.hrs_ones = 6'($urandom_range(0, 9));
        bus.min_tens = 6'($urandom_range(0, 9));
        bus.min_ones = 6'($urandom_range(0, 9));
        bus.sec_tens = 6'($urandom_range(0, 9));
        bus.sec_ones = 6'($urandom_range(0, 9));
    endtask

    task automatic test_reset();
        int first_lit;
        reset    = 1'b1;
        bus.mode = 3'd0;
        rand_digits();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== 16'hFFFF) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: an/seg/dp got %h want ffff", i, {bus.an, bus.seg, bus.dp});
            end
        end
        reset     = 1'b0;
        first_lit = -1;
        for (int i = 1; i <= 20 && first_lit < 0; i++) begin
            @(negedge clk);
            if (bus.an !== 8'hFF) first_lit = i;
        end
        total++;
        if (first_lit != 3 || bus.an !== 8'hFE) begin
            bad++;
            $display("FAIL reset_first_lit: got an=%h at cycle %0d want an=fe at cycle 3", bus.an, first_lit);
        end
    endtask

    task automatic test_scan();
        bus.mode = 3'd0;
        rand_digits();
        for (int i = 0; i < 2 * FRAME + 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL scan: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
            total++;
            if (bus.an[7:6] !== 2'b11 || (bus.an != 8'hFF &&
                bus.dp !== ((bus.an == 8'hFB || bus.an == 8'hEF) ? 1'b0 : 1'b1))) begin
                bad++;
                $display("FAIL scan_dp_an: an=%h dp=%b got, want an[7:6]=11 and dp lit only at fb/ef", bus.an, bus.dp);
            end
        end
    endtask

    task automatic test_snapshot();
        int guard = 0;
        while ((n % FRAME) != 20 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.sec_ones = (bus.sec_ones == 6'd9) ? 6'd0 : bus.sec_ones + 6'd1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL snapshot: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
        end
    endtask

    task automatic test_blink();
        int guard = 0;
        bus.mode = 3'd2;
        for (int i = 0; i < 3 * BK + 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL blink_min: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
        end
        while (!((((n - bbase) / BK) % 2) == 1 && (n % BK) > 20) && guard < 4 * BK) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (guard >= 4 * BK) begin
            bad++;
            $display("FAIL blink_wait: hidden phase not reached, got %0d cycles want < %0d", guard, 4 * BK);
        end
        bus.mode = 3'd3;
        for (int i = 0; i < 3 * BK + 10; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL blink_hrs: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
        end
    endtask

    task automatic test_dash();
        bus.mode     = 3'd0;
        bus.hrs_tens = 6'($urandom_range(10, 63));
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL dash: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
            if (i > FRAME + 2 && bus.an == 8'hDF) begin
                total++;
                if (bus.seg !== 7'h3F) begin
                    bad++;
                    $display("FAIL dash_seg: seg got %h want 3f", bus.seg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int first_lit;
        bus.mode = 3'd0;
        rand_digits();
        while ((n % FRAME) != 3 * SD + 4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.an, bus.seg, bus.dp} !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_mid_blank: an/seg/dp got %h want ffff", {bus.an, bus.seg, bus.dp});
        end
        reset     = 1'b0;
        first_lit = -1;
        for (int i = 1; i <= FRAME + 4; i++) begin
            @(negedge clk);
            if (first_lit < 0 && bus.an !== 8'hFF) first_lit = i;
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL reset_mid_resume: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
        end
        total++;
        if (first_lit != 3) begin
            bad++;
            $display("FAIL reset_mid_first: first lit at cycle %0d want 3", first_lit);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            total++;
            if ({bus.an, bus.seg, bus.dp} !== exp_out) begin
                bad++;
                $display("FAIL random: an/seg/dp got %h want %h", {bus.an, bus.seg, bus.dp}, exp_out);
            end
            if ($urandom_range(0, 49) == 0) rand_digits();
            if ($urandom_range(0, 149) == 0) bus.mode = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_snapshot();
        test_blink();
        test_dash();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
